// File: rtl/piso_pkg.sv
// Shared types and width helpers for the PISO chain reader.
package piso_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_DONE   = 3'd4
   } piso_state_t;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/piso_chain_reader_if.sv
// Chain-side and frame-side signals of the PISO chain reader.
interface piso_chain_reader_if #(
   parameter int N_BIT = 16
);
   logic             Start_I;
   logic             Ser_I;
   logic             Sck_O;
   logic             SH_LD_O;
   logic [N_BIT-1:0] Parl_O;
   logic             Valid_O;
   logic             Changed_O;
   logic             Busy_O;

   modport master (
      output Start_I, Ser_I,
      input  Sck_O, SH_LD_O, Parl_O, Valid_O, Changed_O, Busy_O
   );

   modport slave (
      input  Start_I, Ser_I,
      output Sck_O, SH_LD_O, Parl_O, Valid_O, Changed_O, Busy_O
   );
endinterface

// File: rtl/clk_tick_div.sv
// Free-running DIV-cycle down-counter; tick_o marks the last cycle of each phase.
module clk_tick_div
   import piso_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic restart_i,
   output logic tick_o
);
   localparam int            CW     = cnt_width(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
   localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: reload on restart or terminal count, otherwise count down.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i || (cnt_q == ZERO)) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - ONE;
      end
   end

   assign tick_o = (cnt_q == ZERO);

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/piso_chain_reader.sv
// Reads a daisy-chain of 74HC165-style shift registers and publishes each frame
// MSB-first with a valid strobe and a change flag.
module piso_chain_reader
   import piso_pkg::*;
#(
   parameter int N_BIT = 16,
   parameter int DIV   = 4,
   parameter int AUTO  = 1
) (
   input logic                Clk_I,
   input logic                RstN_I,
   piso_chain_reader_if.slave pif
);
   localparam int             BCW       = cnt_width(N_BIT);
   localparam logic [BCW-1:0] LAST_SLOT = BCW'(N_BIT - 1);
   localparam logic [BCW-1:0] BC_ZERO   = {BCW{1'b0}};
   localparam logic [BCW-1:0] BC_ONE    = BCW'(1);

   piso_state_t      state_q, state_d;
   logic             half_q, half_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [N_BIT-1:0] shreg_q, shreg_d;
   logic [N_BIT-1:0] parl_q, parl_d;
   logic             first_q, first_d;
   logic             changed_q, changed_d;
   logic             sck_q, sck_d;
   logic             sh_ld_q, sh_ld_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             tick_s;
   logic             div_restart_s;
   logic [N_BIT-1:0] shift_in_s;

   // IDLE holds the divider so LOAD always starts a full DIV-cycle phase.
   assign div_restart_s = (state_q == ST_IDLE);
   assign shift_in_s    = (shreg_q << 1'b1) | N_BIT'(pif.Ser_I);

   clk_tick_div #(
      .DIV (DIV)
   ) u_div (
      .clk_i     (Clk_I),
      .rst_n_i   (RstN_I),
      .restart_i (div_restart_s),
      .tick_o    (tick_s)
   );

   // Next-state, shift-register and output computation.
   always_comb begin
      state_d   = state_q;
      half_d    = half_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      parl_d    = parl_q;
      first_d   = first_q;
      changed_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((AUTO != 0) || pif.Start_I) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (tick_s) begin
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_SETTLE: begin
            if (tick_s) begin
               state_d   = ST_SHIFT;
               half_d    = 1'b0;
               bit_cnt_d = BC_ZERO;
               shreg_d   = shift_in_s;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SHIFT: begin
            if (!tick_s) begin
               state_d = ST_SHIFT;
            end else if (!half_q) begin
               // Slot 0 low half follows the SETTLE sample, so nothing new is on QH yet.
               half_d = 1'b1;
               if (bit_cnt_q != BC_ZERO) begin
                  shreg_d = shift_in_s;
               end else begin
                  shreg_d = shreg_q;
               end
            end else if (bit_cnt_q == LAST_SLOT) begin
               state_d   = ST_DONE;
               parl_d    = shreg_q;
               changed_d = first_q || (shreg_q != parl_q);
               first_d   = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + BC_ONE;
               half_d    = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      sh_ld_d = (state_d != ST_LOAD);
      sck_d   = (state_d == ST_SHIFT) && half_d;
      valid_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge Clk_I) begin
      if (!RstN_I) begin
         state_q   <= ST_IDLE;
         half_q    <= 1'b0;
         bit_cnt_q <= BC_ZERO;
         shreg_q   <= {N_BIT{1'b0}};
         parl_q    <= {N_BIT{1'b0}};
         first_q   <= 1'b1;
         changed_q <= 1'b0;
         sck_q     <= 1'b0;
         sh_ld_q   <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         half_q    <= half_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         parl_q    <= parl_d;
         first_q   <= first_d;
         changed_q <= changed_d;
         sck_q     <= sck_d;
         sh_ld_q   <= sh_ld_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

   assign pif.Sck_O     = sck_q;
   assign pif.SH_LD_O   = sh_ld_q;
   assign pif.Parl_O    = parl_q;
   assign pif.Valid_O   = valid_q;
   assign pif.Changed_O = changed_q;
   assign pif.Busy_O    = busy_q;

endmodule

// File: tb/tb_piso_chain_reader.sv
// Directed bench: four reader instances, each driven by a behavioural 74HC165 chain.
module tb_piso_chain_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   piso_chain_reader_if #(.N_BIT(16)) if_a ();
   piso_chain_reader_if #(.N_BIT(16)) if_b ();
   piso_chain_reader_if #(.N_BIT(1))  if_c ();
   piso_chain_reader_if #(.N_BIT(24)) if_d ();

   piso_chain_reader #(.N_BIT(16), .DIV(4), .AUTO(0)) u_a (.Clk_I(clk), .RstN_I(rst_a), .pif(if_a.slave));
   piso_chain_reader #(.N_BIT(16), .DIV(4), .AUTO(1)) u_b (.Clk_I(clk), .RstN_I(rst_b), .pif(if_b.slave));
   piso_chain_reader #(.N_BIT(1),  .DIV(1), .AUTO(0)) u_c (.Clk_I(clk), .RstN_I(rst_c), .pif(if_c.slave));
   piso_chain_reader #(.N_BIT(24), .DIV(3), .AUTO(0)) u_d (.Clk_I(clk), .RstN_I(rst_d), .pif(if_d.slave));

   // Chain models: parallel load while SH/LD is low, shift toward QH on Sck rise.
   logic [15:0] pat_a, chain_a, pat_b, chain_b;
   logic [0:0]  pat_c, chain_c;
   logic [23:0] pat_d, chain_d;
   logic        sp_a = 1'b0, sp_b = 1'b0, sp_c = 1'b0, sp_d = 1'b0;

   always @(posedge clk) begin
      sp_a <= if_a.Sck_O;
      if (!if_a.SH_LD_O) chain_a <= pat_a;
      else if (if_a.Sck_O && !sp_a) chain_a <= chain_a << 1;
   end
   always @(posedge clk) begin
      sp_b <= if_b.Sck_O;
      if (!if_b.SH_LD_O) chain_b <= pat_b;
      else if (if_b.Sck_O && !sp_b) chain_b <= chain_b << 1;
   end
   always @(posedge clk) begin
      sp_c <= if_c.Sck_O;
      if (!if_c.SH_LD_O) chain_c <= pat_c;
      else if (if_c.Sck_O && !sp_c) chain_c <= chain_c << 1;
   end
   always @(posedge clk) begin
      sp_d <= if_d.Sck_O;
      if (!if_d.SH_LD_O) chain_d <= pat_d;
      else if (if_d.Sck_O && !sp_d) chain_d <= chain_d << 1;
   end

   assign if_a.Ser_I = chain_a[15];
   assign if_b.Ser_I = chain_b[15];
   assign if_c.Ser_I = chain_c[0];
   assign if_d.Ser_I = chain_d[23];

   // Observation mux so one frame-runner serves all instances.
   int          obs_sel = 0;
   logic        o_sck, o_shld, o_valid, o_chg, o_busy;
   logic [23:0] o_parl;
   always_comb begin
      o_sck = 1'b0; o_shld = 1'b1; o_valid = 1'b0; o_chg = 1'b0; o_busy = 1'b0; o_parl = 24'd0;
      case (obs_sel)
         0: begin o_sck = if_a.Sck_O; o_shld = if_a.SH_LD_O; o_valid = if_a.Valid_O;
                  o_chg = if_a.Changed_O; o_busy = if_a.Busy_O; o_parl = 24'(if_a.Parl_O); end
         2: begin o_sck = if_c.Sck_O; o_shld = if_c.SH_LD_O; o_valid = if_c.Valid_O;
                  o_chg = if_c.Changed_O; o_busy = if_c.Busy_O; o_parl = 24'(if_c.Parl_O); end
         3: begin o_sck = if_d.Sck_O; o_shld = if_d.SH_LD_O; o_valid = if_d.Valid_O;
                  o_chg = if_d.Changed_O; o_busy = if_d.Busy_O; o_parl = 24'(if_d.Parl_O); end
         default: ;
      endcase
   end

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0: if_a.Start_I = v;
         2: if_c.Start_I = v;
         3: if_d.Start_I = v;
         default: ;
      endcase
   endtask

   task automatic set_rst(input int sel, input logic v);
      case (sel)
         0: rst_a = v;
         2: rst_c = v;
         3: rst_d = v;
         default: ;
      endcase
   endtask

   // Frame-runner results; sample n is the cycle t+n after the Start cycle t.
   int          r_valid_at, r_n_valid, r_rises, r_shld_low, r_busy_cnt, r_busy_first, r_busy_last;
   logic [23:0] r_parl, s_parl;
   logic        r_chg, s_shld, s_sck, s_busy, s_valid;

   task automatic run_frame(input int sel, input int n_max, input int restart_at, input int rst_at);
      logic prev_sck;
      prev_sck = 1'b0;
      r_valid_at = 0; r_n_valid = 0; r_rises = 0; r_shld_low = 0;
      r_busy_cnt = 0; r_busy_first = 0; r_busy_last = 0; r_parl = 24'd0; r_chg = 1'b0;
      obs_sel = sel;
      @(negedge clk);
      set_start(sel, 1'b1);
      for (int n = 1; n <= n_max; n++) begin
         @(posedge clk);
         @(negedge clk);
         set_start(sel, n == restart_at);
         set_rst(sel, !(n == rst_at));
         if (n == rst_at + 1) begin
            s_shld = o_shld; s_sck = o_sck; s_busy = o_busy; s_valid = o_valid; s_parl = o_parl;
         end
         if (o_sck && !prev_sck) r_rises++;
         prev_sck = o_sck;
         if (!o_shld) r_shld_low++;
         if (o_busy) begin
            r_busy_cnt++;
            if (r_busy_first == 0) r_busy_first = n;
            r_busy_last = n;
         end
         if (o_valid) begin
            r_n_valid++;
            if (r_valid_at == 0) begin
               r_valid_at = n; r_parl = o_parl; r_chg = o_chg;
            end
         end
      end
   endtask

   task automatic test_reset();
      n_checks++; if (if_a.SH_LD_O !== 1'b1) begin n_fail++; $display("FAIL rst_shld: got %b expected 1", if_a.SH_LD_O); end
      n_checks++; if (if_a.Sck_O !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b expected 0", if_a.Sck_O); end
      n_checks++; if (if_a.Parl_O !== 16'h0000) begin n_fail++; $display("FAIL rst_parl: got %h expected 0000", if_a.Parl_O); end
      n_checks++; if (if_a.Valid_O !== 1'b0 || if_a.Changed_O !== 1'b0) begin n_fail++; $display("FAIL rst_valid_chg: got %b%b expected 00", if_a.Valid_O, if_a.Changed_O); end
      n_checks++; if (if_a.Busy_O !== 1'b0 || if_b.Busy_O !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b%b expected 00", if_a.Busy_O, if_b.Busy_O); end
      n_checks++; if (if_d.Parl_O !== 24'h000000) begin n_fail++; $display("FAIL rst_parl_d: got %h expected 000000", if_d.Parl_O); end
   endtask

   task automatic wait_valid_b(input int limit, output int waited);
      waited = -1;
      for (int n = 1; n <= limit; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (if_b.Valid_O) begin waited = n; break; end
      end
   endtask

   task automatic test_change();
      int w;
      wait_valid_b(400, w);
      n_checks++; if (w < 0) begin n_fail++; $display("FAIL chg_f1_timeout: got %0d expected valid", w); end
      n_checks++; if (if_b.Changed_O !== 1'b1 || if_b.Parl_O !== 16'h00FF) begin n_fail++; $display("FAIL chg_f1: got chg=%b parl=%h expected 1/00FF", if_b.Changed_O, if_b.Parl_O); end
      wait_valid_b(400, w);
      n_checks++; if (w !== 138) begin n_fail++; $display("FAIL chg_f2_spacing: got %0d expected 138", w); end
      n_checks++; if (if_b.Changed_O !== 1'b0 || if_b.Parl_O !== 16'h00FF) begin n_fail++; $display("FAIL chg_f2: got chg=%b parl=%h expected 0/00FF", if_b.Changed_O, if_b.Parl_O); end
      pat_b = 16'h01FF;
      wait_valid_b(400, w);
      n_checks++; if (w !== 138) begin n_fail++; $display("FAIL chg_f3_spacing: got %0d expected 138", w); end
      n_checks++; if (if_b.Changed_O !== 1'b1 || if_b.Parl_O !== 16'h01FF) begin n_fail++; $display("FAIL chg_f3: got chg=%b parl=%h expected 1/01FF", if_b.Changed_O, if_b.Parl_O); end
      wait_valid_b(400, w);
      n_checks++; if (if_b.Changed_O !== 1'b0) begin n_fail++; $display("FAIL chg_f4: got chg=%b expected 0", if_b.Changed_O); end
   endtask

   task automatic test_msb_first();
      pat_a = 16'hA5C3;
      run_frame(0, 160, -1, -1);
      n_checks++; if (r_valid_at !== 137) begin n_fail++; $display("FAIL msb_valid_at: got %0d expected 137", r_valid_at); end
      n_checks++; if (r_parl !== 24'h00A5C3) begin n_fail++; $display("FAIL msb_parl: got %h expected 00a5c3", r_parl); end
      n_checks++; if (r_chg !== 1'b1) begin n_fail++; $display("FAIL msb_changed: got %b expected 1", r_chg); end
      n_checks++; if (r_rises !== 16) begin n_fail++; $display("FAIL msb_sck_rises: got %0d expected 16", r_rises); end
      n_checks++; if (r_shld_low !== 4) begin n_fail++; $display("FAIL msb_shld_low: got %0d expected 4", r_shld_low); end
      n_checks++; if (r_n_valid !== 1) begin n_fail++; $display("FAIL msb_n_valid: got %0d expected 1", r_n_valid); end
   endtask

   task automatic test_busy_start();
      pat_a = 16'h5A3C;
      run_frame(0, 300, 60, -1);
      n_checks++; if (r_n_valid !== 1) begin n_fail++; $display("FAIL busy_n_valid: got %0d expected 1", r_n_valid); end
      n_checks++; if (r_busy_first !== 1 || r_busy_last !== 137 || r_busy_cnt !== 137) begin n_fail++;
         $display("FAIL busy_window: got %0d..%0d (%0d) expected 1..137 (137)", r_busy_first, r_busy_last, r_busy_cnt); end
      n_checks++; if (r_valid_at !== 137 || r_parl !== 24'h005A3C || r_chg !== 1'b1) begin n_fail++;
         $display("FAIL busy_frame: got at=%0d parl=%h chg=%b expected 137/005a3c/1", r_valid_at, r_parl, r_chg); end
   endtask

   task automatic test_reset_mid();
      pat_a = 16'h1234;
      run_frame(0, 200, 50, 50);
      n_checks++; if (s_shld !== 1'b1 || s_sck !== 1'b0 || s_busy !== 1'b0 || s_valid !== 1'b0) begin n_fail++;
         $display("FAIL rmid_ctrl: got shld=%b sck=%b busy=%b valid=%b expected 1000", s_shld, s_sck, s_busy, s_valid); end
      n_checks++; if (s_parl !== 24'h000000) begin n_fail++; $display("FAIL rmid_parl: got %h expected 000000", s_parl); end
      n_checks++; if (r_n_valid !== 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d expected 0", r_n_valid); end
      run_frame(0, 160, -1, -1);
      n_checks++; if (r_valid_at !== 137 || r_parl !== 24'h001234 || r_chg !== 1'b1) begin n_fail++;
         $display("FAIL rmid_next: got at=%0d parl=%h chg=%b expected 137/001234/1", r_valid_at, r_parl, r_chg); end
   endtask

   task automatic test_corners();
      pat_c = 1'b1;
      run_frame(2, 20, -1, -1);
      n_checks++; if (r_valid_at !== 5 || r_busy_cnt !== 5 || r_busy_last !== 5) begin n_fail++;
         $display("FAIL c1_length: got valid=%0d busy=%0d last=%0d expected 5/5/5", r_valid_at, r_busy_cnt, r_busy_last); end
      n_checks++; if (r_parl !== 24'h000001 || r_chg !== 1'b1) begin n_fail++; $display("FAIL c1_parl: got %h chg=%b expected 000001/1", r_parl, r_chg); end
      n_checks++; if (r_rises !== 1) begin n_fail++; $display("FAIL c1_rises: got %0d expected 1", r_rises); end
      pat_d = 24'h800001;
      run_frame(3, 180, -1, -1);
      n_checks++; if (r_valid_at !== 151) begin n_fail++; $display("FAIL c24_valid_at: got %0d expected 151", r_valid_at); end
      n_checks++; if (r_parl[23] !== 1'b1 || r_parl[0] !== 1'b1) begin n_fail++; $display("FAIL c24_end_bits: got %b%b expected 11", r_parl[23], r_parl[0]); end
      n_checks++; if (r_parl !== 24'h800001) begin n_fail++; $display("FAIL c24_parl: got %h expected 800001", r_parl); end
      n_checks++; if (r_rises !== 24) begin n_fail++; $display("FAIL c24_rises: got %0d expected 24", r_rises); end
   endtask

   initial begin
      if_a.Start_I = 1'b0; if_b.Start_I = 1'b0; if_c.Start_I = 1'b0; if_d.Start_I = 1'b0;
      pat_a = 16'h0000; pat_b = 16'h00FF; pat_c = 1'b0; pat_d = 24'h000000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
      test_change();
      test_msb_first();
      test_busy_start();
      test_reset_mid();
      test_corners();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
